// File: rtl/vend_pkg.sv
// Shared types and constants for the vending slice.
// Holds the dispenser FSM state type, the credit-state encodings the
// upstream vending FSM uses, the coin width and the default stock width.
package vend_pkg;

  localparam int COIN_W      = 1;
  localparam int STOCK_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2,
    FAULT   = 2'd3
  } disp_state_t;

  // Credit states of the upstream vending FSM (credit held = state value).
  typedef enum logic [2:0] {
    CREDIT_0 = 3'd0,
    CREDIT_1 = 3'd1,
    CREDIT_2 = 3'd2,
    CREDIT_3 = 3'd3,
    CREDIT_4 = 3'd4
  } vend_state_t;

endpackage

// File: rtl/vend_pend_counter.sv
// Pending-vend counter: saturating up/down counter with a sticky overflow
// flag.
// Ports:
//   clk, rst          clock, async active-high reset
//   inc               request to add one pending vend
//   dec               FSM accepted a vend (only asserted when count > 0)
//   count             current number of queued vends
//   overflow          sticky: an increment was dropped at PEND_MAX
module vend_pend_counter #(
  parameter int PEND_MAX = 3,
  parameter int PEND_W   = $clog2(PEND_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] count,
  output logic              overflow
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // Simultaneous inc/dec cancel out, so a full queue never drops a vend
      // in the cycle the FSM takes one out.
      if (inc && !dec) begin
        if (count == PEND_W'(PEND_MAX))
          overflow <= 1'b1;
        else
          count <= count + 1'b1;
      end else if (dec && !inc) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/vend_dispenser.sv
// Vend dispenser: queues vend pulses from the vending FSM, runs a req/ack
// handshake with the motor driver, tracks stock, refunds vends that cannot
// be served and faults when the motor never acknowledges.
// Ports:
//   clk, reset        clock, async active-high reset
//   io_vend           one-cycle vend pulse
//   io_motor_ack      motor acknowledge (level)
//   io_refill_valid   refill strobe, io_refill_qty items added
//   io_clear          leaves FAULT
//   io_motor_req      motor request (level)
//   io_refund         one-cycle refund pulse
//   io_overflow       sticky: a vend was dropped on a full queue
//   io_sold_out       stock == 0
//   io_fault          FSM is in FAULT
//   io_stock          current stock
// Build option VEND_DISPENSER_STATS_EN adds io_vend_count and
// io_refund_count (16-bit wrapping event counters).
module vend_dispenser import vend_pkg::*; #(
  parameter int STOCK_W    = STOCK_W_DEF,
  parameter int STOCK_INIT = 16,
  parameter int PEND_MAX   = 3,
  parameter int TIMEOUT    = 200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               io_vend,
  input  logic               io_motor_ack,
  input  logic               io_refill_valid,
  input  logic [STOCK_W-1:0] io_refill_qty,
  input  logic               io_clear,
  output logic               io_motor_req,
  output logic               io_refund,
  output logic               io_overflow,
  output logic               io_sold_out,
  output logic               io_fault,
  output logic [STOCK_W-1:0] io_stock
`ifdef VEND_DISPENSER_STATS_EN
  ,
  output logic [15:0]        io_vend_count,
  output logic [15:0]        io_refund_count
`endif
);

  localparam int PEND_W = $clog2(PEND_MAX + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);

  disp_state_t         state;
  logic [PEND_W-1:0]   pending;
  logic [STOCK_W-1:0]  stock;
  logic [TMR_W-1:0]    timer;
  logic                accept;
  logic                ack_dec;
  logic [STOCK_W-1:0]  refill_add;
  logic [STOCK_W:0]    stock_sum;
  logic [STOCK_W-1:0]  stock_next;

  assign accept  = (state == IDLE) && (pending != '0);
  assign ack_dec = (state == REQ) && io_motor_ack;

  vend_pend_counter #(
    .PEND_MAX (PEND_MAX),
    .PEND_W   (PEND_W)
  ) u_pend (
    .clk      (clk),
    .rst      (reset),
    .inc      (io_vend),
    .dec      (accept),
    .count    (pending),
    .overflow (io_overflow)
  );

  // Refill and ack-decrement merge into one saturating update. The
  // subtraction cannot borrow: REQ is only entered with stock > 0 and a
  // refill never lowers stock, so the extra bit only ever flags overflow.
  assign refill_add = io_refill_valid ? io_refill_qty : '0;
  assign stock_sum  = {1'b0, stock} + {1'b0, refill_add}
                    - {{STOCK_W{1'b0}}, ack_dec};
  assign stock_next = stock_sum[STOCK_W] ? '1 : stock_sum[STOCK_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      stock        <= STOCK_W'(STOCK_INIT);
      timer        <= '0;
      io_motor_req <= 1'b0;
      io_refund    <= 1'b0;
      io_fault     <= 1'b0;
    end else begin
      stock     <= stock_next;
      io_refund <= 1'b0;
      case (state)
        IDLE: begin
          if (pending != '0) begin
            if (stock != '0) begin
              state        <= REQ;
              timer        <= '0;
              io_motor_req <= 1'b1;
            end else begin
              io_refund <= 1'b1;
            end
          end
        end
        REQ: begin
          if (io_motor_ack) begin
            state        <= RELEASE;
            io_motor_req <= 1'b0;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            state        <= FAULT;
            io_motor_req <= 1'b0;
            io_fault     <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RELEASE: begin
          if (!io_motor_ack)
            state <= IDLE;
        end
        FAULT: begin
          if (io_clear) begin
            state    <= IDLE;
            io_fault <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io_stock    = stock;
  assign io_sold_out = (stock == '0);

`ifdef VEND_DISPENSER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_vend_count   <= '0;
      io_refund_count <= '0;
    end else begin
      if (ack_dec)
        io_vend_count <= io_vend_count + 16'd1;
      if (io_refund)
        io_refund_count <= io_refund_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vend_dispenser.sv
// Testbench for vend_dispenser: scoreboard of expected dispense/refund/
// timeout events, auto-acking motor model, directed boundary checks.
module tb_vend_dispenser;

  localparam int K_DISP   = 0;
  localparam int K_REFUND = 1;
  localparam int K_TMO    = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       io_vend;
  logic       io_motor_ack;
  logic       io_refill_valid;
  logic [7:0] io_refill_qty;
  logic       io_clear;
  logic       io_motor_req;
  logic       io_refund;
  logic       io_overflow;
  logic       io_sold_out;
  logic       io_fault;
  logic [7:0] io_stock;
`ifdef VEND_DISPENSER_STATS_EN
  logic [15:0] io_vend_count;
  logic [15:0] io_refund_count;
`endif

  always #5 clk = ~clk;

  vend_dispenser #(
    .STOCK_W    (8),
    .STOCK_INIT (16),
    .PEND_MAX   (3),
    .TIMEOUT    (200)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .io_vend         (io_vend),
    .io_motor_ack    (io_motor_ack),
    .io_refill_valid (io_refill_valid),
    .io_refill_qty   (io_refill_qty),
    .io_clear        (io_clear),
    .io_motor_req    (io_motor_req),
    .io_refund       (io_refund),
    .io_overflow     (io_overflow),
    .io_sold_out     (io_sold_out),
    .io_fault        (io_fault),
    .io_stock        (io_stock)
`ifdef VEND_DISPENSER_STATS_EN
    ,
    .io_vend_count   (io_vend_count),
    .io_refund_count (io_refund_count)
`endif
  );

  typedef struct {
    int kind;
    int stock;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  bit   cur_valid   = 1'b0;
  bit   sb_on       = 1'b1;
  bit   ack_en      = 1'b1;
  logic man_ack     = 1'b0;
  logic req_q       = 1'b0;
  int   model_stock = 16;
  int   refund_seen = 0;
  int   disp_seen   = 0;
  int   n_cmp       = 0;
  int   n_err       = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_model();
    exp_t e;
    if (model_stock > 0) begin
      model_stock--;
      e.kind  = K_DISP;
      e.stock = model_stock;
    end else begin
      e.kind  = K_REFUND;
      e.stock = 0;
    end
    sb_q.push_back(e);
  endtask

  // n consecutive vend cycles; the first npush are expected to be served.
  task automatic vend_burst(input int n, input int npush);
    @(posedge clk); #1;
    io_vend = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i < npush) push_model();
      @(posedge clk); #1;
    end
    io_vend = 1'b0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((sb_q.size() != 0 || cur_valid || io_motor_req || io_motor_ack)
           && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("quiet_in_time", n < 3000, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!io_motor_req && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("req_rise_in_time", io_motor_req, 1);
  endtask

  // Motor driver model: acks on the third cycle of a request, releases once
  // the request drops. When disabled it forwards man_ack.
  initial begin
    int rc = 0;
    io_motor_ack = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (ack_en) begin
        if (io_motor_req) begin
          rc++;
          if (rc >= 3) io_motor_ack = 1'b1;
        end else begin
          rc = 0;
          io_motor_ack = 1'b0;
        end
      end else begin
        rc = 0;
        io_motor_ack = man_ack;
      end
    end
  end

  // Output monitor: request rise and refund pulses pop the scoreboard; the
  // request fall checks the stock (or fault) the popped entry predicted.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_on && !reset) begin
        if (io_motor_req && !req_q) begin
          disp_seen++;
          check_val("sb_req_expected", sb_q.size() > 0, 1);
          if (sb_q.size() > 0) begin
            cur       = sb_q.pop_front();
            cur_valid = 1'b1;
            check_val("sb_req_not_refund", cur.kind != K_REFUND, 1);
          end
        end
        if (!io_motor_req && req_q && cur_valid) begin
          if (cur.kind == K_TMO)
            check_val("sb_timeout_fault", io_fault, 1);
          else
            check_val("sb_stock_after", io_stock, cur.stock);
          cur_valid = 1'b0;
        end
        if (io_refund) begin
          refund_seen++;
          check_val("sb_refund_expected", sb_q.size() > 0, 1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val("sb_refund_kind", e.kind, K_REFUND);
          end
        end
      end
      req_q = io_motor_req;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int s0;
    int d0;
    int r0;
    exp_t e;
    reset           = 1'b1;
    io_vend         = 1'b0;
    io_refill_valid = 1'b0;
    io_refill_qty   = 8'd0;
    io_clear        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_req", io_motor_req, 0);
    check_val("rst_refund", io_refund, 0);
    check_val("rst_overflow", io_overflow, 0);
    check_val("rst_fault", io_fault, 0);
    check_val("rst_sold_out", io_sold_out, 0);
    check_val("rst_stock", io_stock, 16);
`ifdef VEND_DISPENSER_STATS_EN
    check_val("rst_vend_count", io_vend_count, 0);
    check_val("rst_refund_count", io_refund_count, 0);
`endif
    reset = 1'b0;

    // Basic vend with latency: pending at N+1, request at N+2.
    @(posedge clk); #1;
    io_vend = 1'b1;
    push_model();
    @(posedge clk); #1;
    io_vend = 1'b0;
    check_val("lat_n1_req", io_motor_req, 0);
    @(posedge clk); #1;
    check_val("lat_n2_req", io_motor_req, 1);
    wait_quiet();
    check_val("basic_stock", io_stock, 15);

    vend_burst(2, 2);
    wait_quiet();
    vend_burst(1, 1);
    wait_quiet();
    check_val("seq_stock", io_stock, model_stock);

    // Overflow: motor stalled, 5 back-to-back vends, one dropped.
    ack_en = 1'b0;
    d0 = disp_seen;
    vend_burst(5, 4);
    check_val("ovf_flag", io_overflow, 1);
    check_val("ovf_req_held", io_motor_req, 1);
    ack_en = 1'b1;
    wait_quiet();
    repeat (20) @(posedge clk);
    #1;
    check_val("ovf_dispense_count", disp_seen - d0, 4);
    check_val("ovf_stock", io_stock, model_stock);

    // Timeout: first vend faults after 200 REQ cycles, second stays queued.
    ack_en = 1'b0;
    s0 = model_stock;
    e.kind  = K_TMO;
    e.stock = s0;
    sb_q.push_back(e);
    vend_burst(2, 0);
    push_model();
    wait_req();
    n = 0;
    while (!io_fault && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("tmo_cycles", n, 200);
    check_val("tmo_req_low", io_motor_req, 0);
    check_val("tmo_stock", io_stock, s0);
    ack_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("fault_holds", io_fault, 1);
    check_val("fault_no_req", io_motor_req, 0);
    @(posedge clk); #1;
    io_clear = 1'b1;
    @(posedge clk); #1;
    io_clear = 1'b0;
    check_val("clear_fault", io_fault, 0);
    wait_quiet();
    check_val("after_clear_stock", io_stock, model_stock);

    vend_burst(1, 1);
    wait_quiet();
    vend_burst(1, 1);
    wait_quiet();
    check_val("pre_race_stock", io_stock, 5);

    // Refill in the same cycle as the ack, then saturation.
    sb_on  = 1'b0;
    ack_en = 1'b0;
    vend_burst(1, 0);
    wait_req();
    @(posedge clk); #1;
    man_ack         = 1'b1;
    io_refill_valid = 1'b1;
    io_refill_qty   = 8'd10;
    @(posedge clk); #1;
    man_ack         = 1'b0;
    io_refill_valid = 1'b0;
    check_val("race_stock", io_stock, 14);
    check_val("race_req_low", io_motor_req, 0);
    repeat (3) @(posedge clk);
    #1;
    io_refill_valid = 1'b1;
    io_refill_qty   = 8'd236;
    @(posedge clk); #1;
    check_val("refill_250", io_stock, 250);
    io_refill_qty   = 8'd255;
    @(posedge clk); #1;
    io_refill_valid = 1'b0;
    check_val("refill_sat", io_stock, 255);
    model_stock = 255;
    sb_on = 1'b1;

    // Async reset in the middle of a request.
    ack_en = 1'b0;
    sb_on  = 1'b0;
    vend_burst(2, 0);
    wait_req();
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check_val("arst_req", io_motor_req, 0);
    check_val("arst_stock", io_stock, 16);
    check_val("arst_overflow", io_overflow, 0);
`ifdef VEND_DISPENSER_STATS_EN
    check_val("arst_vend_count", io_vend_count, 0);
    check_val("arst_refund_count", io_refund_count, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    cur_valid   = 1'b0;
    model_stock = 16;
    ack_en      = 1'b1;
    sb_on       = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_val("arst_queue_lost", io_motor_req, 0);

    // Drain all stock, then two back-to-back vends refund.
    for (int i = 0; i < 16; i++) begin
      vend_burst(1, 1);
      wait_quiet();
    end
    check_val("drain_stock", io_stock, 0);
    check_val("drain_sold_out", io_sold_out, 1);
    r0 = refund_seen;
    d0 = disp_seen;
    vend_burst(2, 2);
    wait_quiet();
    repeat (3) @(posedge clk);
    #1;
    check_val("soldout_refunds", refund_seen - r0, 2);
    check_val("soldout_no_req", disp_seen - d0, 0);
    check_val("soldout_stock", io_stock, 0);
    check_val("soldout_flag", io_sold_out, 1);
`ifdef VEND_DISPENSER_STATS_EN
    check_val("stats_vend_count", io_vend_count, 16);
    check_val("stats_refund_count", io_refund_count, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vend_dispenser.md
Name: vend_dispenser

Overview:
- Downstream of the vending FSM; consumes its one-cycle io_valid "vend" pulse.
- Queues pending vends, runs a req/ack handshake with the motor driver, and tracks inventory.
- Refunds vends it cannot serve and faults on motor timeout.

Parameters:
- STOCK_W, 8, width of stock counter and refill quantity.
- STOCK_INIT, 16, stock value loaded at reset.
- PEND_MAX, 3, maximum queued vends (pending counter width = clog2(PEND_MAX+1)).
- TIMEOUT, 200, cycles in REQ without ack before fault (timer width = clog2(TIMEOUT+1)).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_vend  in  1  one-cycle vend pulse from the vending FSM's io_valid.
- io_motor_ack  in  1  motor driver acknowledge (level).
- io_refill_valid  in  1  refill strobe.
- io_refill_qty  in  STOCK_W  items added on refill.
- io_clear  in  1  fault clear.
- io_motor_req  out  1  motor request (level).
- io_refund  out  1  one-cycle refund pulse.
- io_overflow  out  1  sticky: a vend was dropped because the queue was full.
- io_sold_out  out  1  stock == 0.
- io_fault  out  1  FSM in FAULT.
- io_stock  out  STOCK_W  current stock.

Behaviour:
- Reset (async, active-high) values:
  - state=IDLE, pending=0, stock=STOCK_INIT, timer=0.
  - io_motor_req=0, io_refund=0, io_overflow=0, io_fault=0.
  - io_sold_out=(STOCK_INIT==0).
- Reset mid-handshake drops io_motor_req at once and loses the pending queue.
- Pending counter:
  - +1 on io_vend; -1 when the FSM accepts a vend (IDLE leaves with pending>0).
  - Simultaneous +1/-1 leaves it unchanged.
  - io_vend while pending==PEND_MAX with no decrement that cycle: vend dropped, io_overflow set. Only reset clears io_overflow.
- FSM states:
  - IDLE, pending>0, stock>0: go to REQ, decrement pending, clear timer.
  - IDLE, pending>0, stock==0: stay IDLE, decrement pending, pulse io_refund for one cycle (one refund per pending vend per cycle).
  - REQ: io_motor_req=1 and timer increments.
    - io_motor_ack=1: decrement stock, go to RELEASE.
    - Else, timer==TIMEOUT-1: go to FAULT (no stock change).
  - RELEASE: io_motor_req=0; when io_motor_ack=0, go to IDLE.
  - FAULT: io_motor_req=0, io_fault=1; io_vend still queues; io_clear=1 goes to IDLE.
- Latency: io_vend at cycle N gives io_motor_req=1 at N+2 when IDLE and stock>0 (N+1 pending registered, N+2 state=REQ). A refund pulses at N+2.
- Stock arithmetic:
  - Refill adds io_refill_qty, saturating at 2^STOCK_W-1.
  - A refill and an ack-decrement in the same cycle apply as stock + qty - 1, saturating.
  - Stock never underflows; a decrement occurs only from REQ, which requires stock>0 at entry, and refill cannot reduce stock.
- io_sold_out and io_stock are registered, combinationally derived from the stock register.
- io_clear outside FAULT is ignored.

Optional Feature:
- Macro VEND_DISPENSER_STATS_EN.
- Defined:
  - Adds output io_vend_count (16 bits), reset 0, +1 per successful ack, wraps 0xFFFF -> 0.
  - Adds output io_refund_count (16 bits), reset 0, +1 per io_refund pulse, wrapping.
- Undefined: neither port nor register exists; all other behaviour is identical.

Decomposition:
- Package vend_pkg holds:
  - state enum {IDLE, REQ, RELEASE, FAULT}, 2 bits.
  - Shared width constant COIN_W=1 and vend-state encodings used by the vending FSM (credit states 0-4).
  - STOCK_W default.
- One natural sub-module, vend_pend_counter: saturating up/down counter with overflow flag, parameterised by PEND_MAX.
- FSM, stock logic and timer stay in the top module.

Test Plan:
- Basic vend: stock=16, single io_vend; ack asserted 3 cycles after req -> req high from N+2 until ack, stock=15, req low, IDLE after ack falls.
- Sold out: STOCK_INIT=1, two vends back-to-back:
  - First dispenses; second produces exactly one io_refund pulse.
  - io_sold_out=1, stock stays 0.
- Queue overflow: 5 vends in consecutive cycles while motor is held without ack -> pending saturates at 3, io_overflow=1, only 4 dispenses occur (1 in flight + 3 queued).
- Timeout: no ack for 200 cycles in REQ -> io_fault=1 at cycle 200, req low, stock unchanged; io_clear -> IDLE, next queued vend re-requests.
- Refill race: stock=5, refill qty=10 in the same cycle as ack -> stock=14; refill qty=255 at stock=250 -> stock=255.
- Async reset asserted mid-REQ -> req drops without a clock edge, stock=STOCK_INIT; with VEND_DISPENSER_STATS_EN, counters return to 0.
